onn_sequencer: RTL and testbench

Sequences a bank of `N` oscillator neurons through load, run and convergence-check phases. The block sits between the host/top-level and the neuron array. It drives the per-array reset pair (`re`/`re_n` pattern), broadcasts the initial phases, and generates the `full_tick`, `drop` and `state_cheak` strobes. It watches the neurons' `state_changed` flags to decide when the network has settled or has timed out.

---
 rtl/onn_sequencer.sv | 153 +++++++++++++++
 tb/tb_onn_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onn_sequencer.sv
// onn_sequencer
// Sequences a bank of N oscillator neurons through load, run and
// convergence-check phases. It drives the neuron reset pair, fans out the
// latched initial phases, and generates the per-period strobes. It also
// watches the neurons' state_changed flags to decide whether the network
// has settled or has timed out.
//
// Ports:
//   sclk          system clock, rising edge
//   re            asynchronous active-high reset of this block
//   start         one-cycle run request, honoured only in IDLE or DONE
//   init_phases   initial phases, neuron i at [i*PHASE_W +: PHASE_W]
//   state_changed per-neuron "phase changed at last check" flags
//   nrn_re        neuron re  (IDLE 0, LOAD 1, RUN 0, DONE 0)
//   nrn_re_n      neuron re_n (IDLE 1, LOAD 0, RUN 0, DONE 0)
//   ini_phase     registered copy of init_phases
//   full_tick     end-of-period strobe (pc == PERIOD-1)
//   drop          pre-tick strobe (pc == PERIOD-2)
//   state_cheak   state-check strobe (pc == 0, not in the first period)
//   busy          high in LOAD and RUN
//   done          high in DONE
//   converged     valid with done: 1 settled, 0 timeout
//   period_count  periods completed in the current or last run (saturates)
module onn_sequencer #(
    parameter int N              = 4,
    parameter int PHASE_W        = 4,
    parameter int PERIOD         = 16,
    parameter int LOAD_CYCLES    = 2,
    parameter int STABLE_PERIODS = 3,
    parameter int MAX_PERIODS    = 200
) (
    input  logic                 sclk,
    input  logic                 re,
    input  logic                 start,
    input  logic [N*PHASE_W-1:0] init_phases,
    input  logic [N-1:0]         state_changed,
    output logic                 nrn_re,
    output logic                 nrn_re_n,
    output logic [N*PHASE_W-1:0] ini_phase,
    output logic                 full_tick,
    output logic                 drop,
    output logic                 state_cheak,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [7:0]           period_count
);

    localparam int PC_W = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [7:0]      load_cnt;
    logic [7:0]      stable_cnt;
    logic            first_period;
    logic            sample_now;

    // Phase counter successor and the sample-cycle qualifier. The strobes are
    // registered, so they are computed from the pc value the next cycle holds.
    always_comb begin
        pc_next    = (pc == PC_W'(PERIOD - 1)) ? '0 : pc + 1'b1;
        sample_now = (state == RUN) && (pc == PC_W'(1)) && !first_period;
    end

    // Main sequencer. The exit decision on a sample cycle looks at the stable
    // count accumulated by earlier samples, so the network must show
    // STABLE_PERIODS quiet samples before the deciding sample. That is why
    // the shortest run is STABLE_PERIODS+1 periods.
    always_ff @(posedge sclk or posedge re) begin
        if (re) begin
            state        <= IDLE;
            pc           <= '0;
            load_cnt     <= '0;
            stable_cnt   <= '0;
            first_period <= 1'b0;
            nrn_re       <= 1'b0;
            nrn_re_n     <= 1'b1;
            ini_phase    <= '0;
            full_tick    <= 1'b0;
            drop         <= 1'b0;
            state_cheak  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            converged    <= 1'b0;
            period_count <= '0;
        end else begin
            full_tick   <= 1'b0;
            drop        <= 1'b0;
            state_cheak <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        ini_phase    <= init_phases;
                        period_count <= '0;
                        stable_cnt   <= '0;
                        converged    <= 1'b0;
                        pc           <= '0;
                        load_cnt     <= '0;
                        nrn_re       <= 1'b1;
                        nrn_re_n     <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_cnt == 8'(LOAD_CYCLES - 1)) begin
                        state        <= RUN;
                        pc           <= '0;
                        first_period <= 1'b1;
                        nrn_re       <= 1'b0;
                        nrn_re_n     <= 1'b0;
                    end else begin
                        load_cnt <= load_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (sample_now && (stable_cnt == 8'(STABLE_PERIODS))) begin
                        state     <= DONE;
                        converged <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (sample_now && (period_count >= 8'(MAX_PERIODS))) begin
                        state     <= DONE;
                        converged <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        if (sample_now) begin
                            stable_cnt <= (|state_changed) ? 8'd0 : stable_cnt + 8'd1;
                        end
                        if (pc == PC_W'(PERIOD - 1)) begin
                            first_period <= 1'b0;
                            period_count <= (period_count == 8'hFF) ? 8'hFF
                                                                     : period_count + 8'd1;
                        end
                        pc          <= pc_next;
                        drop        <= (pc_next == PC_W'(PERIOD - 2));
                        full_tick   <= (pc_next == PC_W'(PERIOD - 1));
                        state_cheak <= (pc_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onn_sequencer.sv
// tb_onn_sequencer
// Randomized self-checking bench for onn_sequencer. The reference model works
// in terms of "cycles since RUN entry". The phase is t % PERIOD and the period
// index is t / PERIOD. The run length comes from replaying the per-period
// sample plan against the settle/timeout rules.
module tb_onn_sequencer;

    localparam int N    = 4;
    localparam int PW   = 4;
    localparam int P    = 16;
    localparam int L    = 2;
    localparam int S    = 3;
    localparam int MAXP = 10;

    logic          sclk = 1'b0;
    logic          re;
    logic          start;
    logic [N*PW-1:0] init_phases;
    logic [N-1:0]  state_changed;
    logic          nrn_re;
    logic          nrn_re_n;
    logic [N*PW-1:0] ini_phase;
    logic          full_tick;
    logic          drop;
    logic          state_cheak;
    logic          busy;
    logic          done;
    logic          converged;
    logic [7:0]    period_count;

    int errors = 0;
    int checks = 0;

    // Value driven on state_changed during the sample of period p (p >= 1).
    logic [3:0] chg_plan [0:255];

    onn_sequencer #(
        .N(N), .PHASE_W(PW), .PERIOD(P), .LOAD_CYCLES(L),
        .STABLE_PERIODS(S), .MAX_PERIODS(MAXP)
    ) dut (
        .sclk(sclk), .re(re), .start(start), .init_phases(init_phases),
        .state_changed(state_changed), .nrn_re(nrn_re), .nrn_re_n(nrn_re_n),
        .ini_phase(ini_phase), .full_tick(full_tick), .drop(drop),
        .state_cheak(state_cheak), .busy(busy), .done(done),
        .converged(converged), .period_count(period_count)
    );

    always #5 sclk = ~sclk;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    // Replays the settle/timeout rules period by period and returns the
    // period whose sample ends the run, plus the expected converged flag.
    task automatic model_end(output int pe, output bit conv);
        int stable;
        stable = 0;
        pe     = 0;
        conv   = 1'b0;
        for (int p = 1; p <= 255; p++) begin
            if (stable >= S) begin
                pe = p; conv = 1'b1; break;
            end
            if (p >= MAXP) begin
                pe = p; conv = 1'b0; break;
            end
            stable = (chg_plan[p] != 4'd0) ? 0 : stable + 1;
        end
    endtask

    // Launches a run and checks every cycle of LOAD, RUN and a DONE tail
    // against the model. With mid_start a start pulse is injected during RUN.
    task automatic do_run(input logic [15:0] phases, input bit mid_start, input string tag);
        int pe;
        bit conv;
        int pcm;
        int per;
        logic [2:0] exp_s;
        model_end(pe, conv);
        init_phases = phases;
        start = 1'b1;
        step();
        start = 1'b0;
        init_phases = 16'($urandom);
        for (int i = 0; i < L; i++) begin
            checks++;
            if ({nrn_re, nrn_re_n, busy, done} !== 4'b1010 || ini_phase !== phases ||
                period_count !== 8'd0 || converged !== 1'b0 ||
                {drop, full_tick, state_cheak} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL %s load%0d: re,re_n,busy,done=%b ini=%h cnt=%0d conv=%b strb=%b, want 1010 ini=%h cnt=0 conv=0 strb=000",
                         tag, i, {nrn_re, nrn_re_n, busy, done}, ini_phase, period_count,
                         converged, {drop, full_tick, state_cheak}, phases);
            end
            step();
        end
        for (int t = 0; t <= pe * P + 1; t++) begin
            pcm   = t % P;
            per   = t / P;
            exp_s = {pcm == P - 2, pcm == P - 1, (pcm == 0) && (per > 0)};
            checks++;
            if ({drop, full_tick, state_cheak} !== exp_s ||
                {nrn_re, nrn_re_n, busy, done} !== 4'b0010 ||
                period_count !== 8'(per) || ini_phase !== phases) begin
                errors++;
                $display("[TB] FAIL %s run t=%0d: strb=%b ctl=%b cnt=%0d ini=%h, want strb=%b ctl=0010 cnt=%0d ini=%h",
                         tag, t, {drop, full_tick, state_cheak}, {nrn_re, nrn_re_n, busy, done},
                         period_count, ini_phase, exp_s, per, phases);
            end
            if (pcm == 1 && per >= 1) state_changed = chg_plan[per];
            else state_changed = 4'($urandom);
            if (mid_start && t == 20) begin
                start = 1'b1;
                init_phases = ~phases;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({nrn_re, nrn_re_n, busy, done} !== 4'b0001 || converged !== conv ||
                period_count !== 8'(pe) || ini_phase !== phases ||
                {drop, full_tick, state_cheak} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL %s done%0d: ctl=%b conv=%b cnt=%0d ini=%h strb=%b, want ctl=0001 conv=%b cnt=%0d ini=%h strb=000",
                         tag, i, {nrn_re, nrn_re_n, busy, done}, converged, period_count,
                         ini_phase, {drop, full_tick, state_cheak}, conv, pe, phases);
            end
            state_changed = 4'($urandom);
            step();
        end
    endtask

    task automatic test_reset();
        re = 1'b1;
        start = 1'b0;
        init_phases = '0;
        state_changed = '0;
        repeat (3) step();
        checks++;
        if ({nrn_re, nrn_re_n, busy, done, converged} !== 5'b01000 || ini_phase !== 16'h0 ||
            period_count !== 8'd0 || {drop, full_tick, state_cheak} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_values: ctl=%b ini=%h cnt=%0d strb=%b, want ctl=01000 ini=0000 cnt=0 strb=000",
                     {nrn_re, nrn_re_n, busy, done, converged}, ini_phase, period_count,
                     {drop, full_tick, state_cheak});
        end
        re = 1'b0;
        for (int i = 0; i < 100; i++) begin
            state_changed = 4'($urandom);
            step();
            checks++;
            if ({nrn_re, nrn_re_n, busy, done} !== 4'b0100 || {drop, full_tick, state_cheak} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL idle%0d: ctl=%b strb=%b, want ctl=0100 strb=000",
                         i, {nrn_re, nrn_re_n, busy, done}, {drop, full_tick, state_cheak});
            end
        end
    endtask

    task automatic test_load_strobes();
        for (int p = 0; p < 256; p++) chg_plan[p] = 4'd0;
        do_run(16'h3A51, 1'b0, "load_strobes");
    endtask

    task automatic test_convergence();
        for (int p = 0; p < 256; p++) chg_plan[p] = (p >= 1 && p <= 5) ? 4'b0010 : 4'd0;
        do_run(16'($urandom), 1'b0, "convergence");
    endtask

    task automatic test_timeout();
        for (int p = 0; p < 256; p++) chg_plan[p] = 4'b1111;
        do_run(16'($urandom), 1'b0, "timeout");
    endtask

    task automatic test_start_handling();
        for (int p = 0; p < 256; p++) chg_plan[p] = 4'd0;
        do_run(16'hC0DE, 1'b1, "start_mid_run");
        for (int p = 0; p < 256; p++) chg_plan[p] = (p == 2) ? 4'b1000 : 4'd0;
        do_run(16'h1234, 1'b0, "start_in_done");
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 256; p++)
                chg_plan[p] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            do_run(16'($urandom), 1'b0, "random_run");
        end
    endtask

    task automatic test_reset_mid_run();
        for (int p = 0; p < 256; p++) chg_plan[p] = 4'b0001;
        init_phases = 16'hBEEF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (L + P + 7) step();
        #2;
        re = 1'b1;
        #1;
        checks++;
        if ({nrn_re, nrn_re_n, busy, done, converged} !== 5'b01000 || ini_phase !== 16'h0 ||
            period_count !== 8'd0 || {drop, full_tick, state_cheak} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL async_reset: ctl=%b ini=%h cnt=%0d strb=%b, want ctl=01000 ini=0000 cnt=0 strb=000",
                     {nrn_re, nrn_re_n, busy, done, converged}, ini_phase, period_count,
                     {drop, full_tick, state_cheak});
        end
        step();
        re = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            checks++;
            if ({nrn_re, nrn_re_n, busy, done} !== 4'b0100 || {drop, full_tick, state_cheak} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL post_reset%0d: ctl=%b strb=%b, want ctl=0100 strb=000",
                         i, {nrn_re, nrn_re_n, busy, done}, {drop, full_tick, state_cheak});
            end
        end
    endtask

    initial begin
        re = 1'b1;
        start = 1'b0;
        init_phases = '0;
        state_changed = '0;
        test_reset();
        test_load_strobes();
        test_convergence();
        test_timeout();
        test_start_handling();
        test_random_runs();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
